// File: rtl/quant_index_packer_if.sv
// Handshake bundle between the divider tail (index side) and the write-back bus (word side).
// The slave modport is the packer; the master modport is whatever drives indices and drains words.
interface quant_index_packer_if #(
    parameter int IDX_W = 8,
    parameter int PACK  = 4
);
    logic                          i_valid;
    logic [IDX_W-1:0]              i_index;
    logic                          i_last;
    logic                          i_clear;
    logic                          o_valid;
    logic                          o_ready;
    logic [IDX_W*PACK-1:0]         o_data;
    logic [$clog2(PACK+1)-1:0]     o_bytes;
    logic                          o_last;
    logic                          o_overflow;

    modport slave (
        input  i_valid, i_index, i_last, i_clear, o_ready,
        output o_valid, o_data, o_bytes, o_last, o_overflow
    );

    modport master (
        output i_valid, i_index, i_last, i_clear, o_ready,
        input  o_valid, o_data, o_bytes, o_last, o_overflow
    );
endinterface

// File: rtl/quant_index_packer.sv
// Packs IDX_W-bit quantized indices into PACK-lane words and queues them in a small FIFO
// ahead of the activation write-back bus; a sticky flag records words lost to a full FIFO.
module quant_index_packer #(
    parameter int IDX_W      = 8,
    parameter int PACK       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    quant_index_packer_if.slave  bus
);
    localparam int W    = IDX_W * PACK;
    localparam int BW   = $clog2(PACK + 1);
    localparam int CNTW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);

    logic [CNTW-1:0]               r_cnt;
    logic [PACK-1:0][IDX_W-1:0]    r_asm;
    logic [PACK-1:0][IDX_W-1:0]    w_word;

    logic [W-1:0]                  r_mem_data  [FIFO_DEPTH];
    logic [BW-1:0]                 r_mem_bytes [FIFO_DEPTH];
    logic                          r_mem_last  [FIFO_DEPTH];
    logic [PW-1:0]                 r_wptr;
    logic [PW-1:0]                 r_rptr;
    logic [CW-1:0]                 r_count;
    logic                          r_overflow;

    logic                          w_done;
    logic                          w_empty;
    logic                          w_full;
    logic                          w_pop;
    logic                          w_push;
    logic                          w_drop;
    logic [BW-1:0]                 w_bytes;

    // The lane being written this cycle is merged in combinationally so a completing
    // index goes straight into the FIFO without an extra assembly cycle.
    for (genvar k = 0; k < PACK; k++) begin : g_lane
        assign w_word[k] = (bus.i_valid && r_cnt == CNTW'(k)) ? bus.i_index : r_asm[k];
    end

    assign w_done  = bus.i_valid && (r_cnt == CNTW'(PACK - 1) || bus.i_last);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_pop   = !w_empty && bus.o_ready;
    assign w_push  = w_done && (!w_full || w_pop);
    assign w_drop  = w_done && w_full && !w_pop;
    assign w_bytes = BW'(r_cnt) + BW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_asm <= '0;
        end else if (bus.i_valid) begin
            if (w_done) begin
                r_cnt <= '0;
                r_asm <= '0;
            end else begin
                r_cnt <= r_cnt + CNTW'(1);
                r_asm <= w_word;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i]  <= '0;
                r_mem_bytes[i] <= '0;
                r_mem_last[i]  <= 1'b0;
            end
        end else if (w_push) begin
            r_mem_data[r_wptr]  <= w_word;
            r_mem_bytes[r_wptr] <= w_bytes;
            r_mem_last[r_wptr]  <= bus.i_last;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally; r_count tells full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A new drop outranks a clear arriving in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_overflow <= 1'b0;
        else if (w_drop)      r_overflow <= 1'b1;
        else if (bus.i_clear) r_overflow <= 1'b0;
    end

    assign bus.o_valid    = !w_empty;
    assign bus.o_data     = w_empty ? '0 : r_mem_data[r_rptr];
    assign bus.o_bytes    = w_empty ? '0 : r_mem_bytes[r_rptr];
    assign bus.o_last     = w_empty ? 1'b0 : r_mem_last[r_rptr];
    assign bus.o_overflow = r_overflow;
endmodule

// File: tb/tb_quant_index_packer.sv
// Directed bench for quant_index_packer: packing, partial flush, backpressure/overflow,
// full-with-pop, overflow clear priority and asynchronous reset mid-word.
module tb_quant_index_packer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    quant_index_packer_if #(.IDX_W(8), .PACK(4)) bus ();

    quant_index_packer #(.IDX_W(8), .PACK(4), .FIFO_DEPTH(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wd(input logic [7:0] b);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_idx(input logic [7:0] idx, input logic last);
        bus.i_valid = 1'b1;
        bus.i_index = idx;
        bus.i_last  = last;
        step();
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
    endtask

    // Fourth index optionally carries o_ready/i_clear; o_ready is left as set.
    task automatic push_word(input logic [7:0] b, input logic rdy4, input logic clr4);
        push_idx(b, 1'b0);
        push_idx(b + 8'd1, 1'b0);
        push_idx(b + 8'd2, 1'b0);
        bus.i_valid = 1'b1;
        bus.i_index = b + 8'd3;
        bus.o_ready = rdy4;
        bus.i_clear = clr4;
        step();
        bus.i_valid = 1'b0;
        bus.i_clear = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.i_valid = 1'b0;
        bus.i_index = '0;
        bus.i_last  = 1'b0;
        bus.i_clear = 1'b0;
        bus.o_ready = 1'b0;
        rst = 1'b1;
        #3;
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_data",  bus.o_data,       32'd0);
        chk("rst_bytes", 32'(bus.o_bytes), 32'd0);
        chk("rst_last",  32'(bus.o_last),  32'd0);
        chk("rst_ovf",   32'(bus.o_overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Full word
        bus.o_ready = 1'b1;
        push_idx(8'h11, 1'b0);
        push_idx(8'h22, 1'b0);
        push_idx(8'h33, 1'b0);
        chk("full_pre_valid", 32'(bus.o_valid), 32'd0);
        push_idx(8'h44, 1'b0);
        chk("full_valid", 32'(bus.o_valid), 32'd1);
        chk("full_data",  bus.o_data,       32'h44332211);
        chk("full_bytes", 32'(bus.o_bytes), 32'd4);
        chk("full_last",  32'(bus.o_last),  32'd0);
        step();
        chk("full_one_cycle", 32'(bus.o_valid), 32'd0);
        chk("full_empty_data", bus.o_data, 32'd0);

        // Partial flush, then next index lands in lane 0
        push_idx(8'hAA, 1'b0);
        chk("part_pre_valid", 32'(bus.o_valid), 32'd0);
        push_idx(8'hBB, 1'b1);
        chk("part_valid", 32'(bus.o_valid), 32'd1);
        chk("part_data",  bus.o_data,       32'h0000BBAA);
        chk("part_bytes", 32'(bus.o_bytes), 32'd2);
        chk("part_last",  32'(bus.o_last),  32'd1);
        push_idx(8'h01, 1'b1);
        chk("lane0_data",  bus.o_data,       32'h00000001);
        chk("lane0_bytes", 32'(bus.o_bytes), 32'd1);
        chk("lane0_last",  32'(bus.o_last),  32'd1);
        step();
        chk("lane0_drained", 32'(bus.o_valid), 32'd0);

        // Backpressure: five words into a four-deep FIFO
        bus.o_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'h10 * 8'(i + 1), 1'b0, 1'b0);
        chk("bp_no_ovf", 32'(bus.o_overflow), 32'd0);
        push_word(8'h50, 1'b0, 1'b0);
        chk("bp_ovf", 32'(bus.o_overflow), 32'd1);
        chk("bp_head_kept", bus.o_data, wd(8'h10));
        bus.o_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_drain%0d", i), bus.o_data, wd(8'h10 * 8'(i + 1)));
            step();
        end
        chk("bp_w4_absent", 32'(bus.o_valid), 32'd0);

        // Clear
        bus.i_clear = 1'b1;
        step();
        bus.i_clear = 1'b0;
        chk("clr_ovf", 32'(bus.o_overflow), 32'd0);

        // Full FIFO with completion and a pop in the same cycle
        bus.o_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'h10 * 8'(i + 1), 1'b0, 1'b0);
        push_word(8'h50, 1'b1, 1'b0);
        chk("fp_no_ovf", 32'(bus.o_overflow), 32'd0);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("fp_drain%0d", i), bus.o_data, wd(8'h10 * 8'(i + 1)));
            step();
        end
        chk("fp_empty", 32'(bus.o_valid), 32'd0);

        // Clear coincident with a new drop: set wins
        bus.o_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(8'h10 * 8'(i + 1), 1'b0, 1'b0);
        chk("cc_ovf_set", 32'(bus.o_overflow), 32'd1);
        push_word(8'h60, 1'b0, 1'b1);
        chk("cc_set_wins", 32'(bus.o_overflow), 32'd1);
        chk("cc_head_kept", bus.o_data, wd(8'h10));

        // Async reset mid-word with two words queued
        bus.o_ready = 1'b1;
        repeat (4) step();
        bus.o_ready = 1'b0;
        push_word(8'h70, 1'b0, 1'b0);
        push_word(8'h80, 1'b0, 1'b0);
        push_idx(8'hE1, 1'b0);
        push_idx(8'hE2, 1'b0);
        chk("ar_pre_valid", 32'(bus.o_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 32'(bus.o_valid), 32'd0);
        chk("ar_data",  bus.o_data,       32'd0);
        chk("ar_ovf",   32'(bus.o_overflow), 32'd0);
        #1 rst = 1'b0;
        push_word(8'h01, 1'b0, 1'b0);
        chk("ar_new_valid", 32'(bus.o_valid), 32'd1);
        chk("ar_new_data",  bus.o_data,       32'h04030201);
        chk("ar_new_bytes", 32'(bus.o_bytes), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/quant_index_packer.md
Name: quant_index_packer

Overview:
- Downstream consumer of the quantizer divider chain: collects the final 8-bit quantized indices emitted by the last divider stage and packs them into 32-bit words for the activation write-back bus.
- A small output FIFO absorbs bus backpressure.
- A sticky overflow flag reports dropped words.
- Sits between the divider pipeline tail and the memory/DMA write port.

Parameters:
- IDX_W, 8, width of one quantized index (bits per lane).
- PACK, 4, lanes per output word; output word width = IDX_W*PACK = 32.
- FIFO_DEPTH, 4, output FIFO entries; must be a power of two, >= 2.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  i_index is a valid result this cycle.
- i_index  input  8  quantized index from final divider stage.
- i_last  input  1  qualifies i_valid; the current index is the last of a tile, so flush the partial word.
- i_clear  input  1  synchronous clear of o_overflow.
- o_valid  output  1  FIFO head holds a word (FIFO count != 0).
- o_ready  input  1  consumer accepts the head word when o_valid is high.
- o_data  output  32  packed word; lane k is bits [8k+7:8k], lane 0 is the first index received.
- o_bytes  output  3  number of valid lanes in o_data, 1..4.
- o_last  output  1  word closes a tile.
- o_overflow  output  1  sticky: a completed word was dropped because the FIFO was full.

Behaviour:
- Reset (async, rst=1): lane counter=0, assembly register=0, FIFO read/write pointers and count=0.
  - Outputs: o_valid=0, o_data=0, o_bytes=0, o_last=0, o_overflow=0.
  - Reset mid-word discards the partial word and all FIFO contents.
- Assembly: lane counter cnt (0..PACK-1). On i_valid=1, i_index is written into lane cnt of the assembly register.
- Word completion: a word completes when i_valid=1 and (cnt==PACK-1 or i_last=1). On completion:
  - Push {data, bytes=cnt+1, last=i_last} into the FIFO.
  - Unwritten upper lanes are zero, and the assembly register's written lane uses the current i_index, so there is no extra cycle.
  - cnt<=0 and the assembly register clears.
- Non-completing index: when i_valid=1 without completion, cnt<=cnt+1.
- i_last with i_valid=0 is ignored. i_last with cnt==PACK-1 produces a full word with last=1.
- Pop: occurs when o_valid && o_ready; the read pointer advances.
- Output signals: o_data, o_bytes and o_last come from the FIFO head storage (registered). They are 0 when the FIFO is empty.
- Latency: an index completing a word at edge N makes o_valid=1 after edge N (visible in cycle N+1).
- Full FIFO with completion and no pop in the same cycle: the word is dropped, o_overflow<=1, and cnt still resets to 0. Existing FIFO contents are untouched.
- Full FIFO with completion and a pop in the same cycle: the push is accepted, the count stays FIFO_DEPTH, and there is no overflow.
- Empty FIFO with a push: no bypass; o_valid rises the next cycle.
- Simultaneous push and pop at other fill levels: count unchanged.
- Pointer wrap: pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. A separate count register distinguishes full from empty.
- Overflow flag: o_overflow is sticky until i_clear=1, which clears it on the next edge. If i_clear and a new overflow occur in the same cycle, the set wins (o_overflow=1).
- o_ready while o_valid=0 has no effect.

Test Plan:
- Full word: indices 0x11,0x22,0x33,0x44 with i_valid on 4 consecutive cycles, o_ready=1 -> one word o_data=0x44332211, o_bytes=4, o_last=0, o_valid high for exactly 1 cycle starting the cycle after the 4th index.
- Partial flush: 0xAA, then 0xBB with i_last=1 -> o_data=0x0000BBAA, o_bytes=2, o_last=1; a following 0x01 lands in lane 0 of a new word.
- Backpressure/overflow: o_ready=0, push 5 full words (W0..W4) -> FIFO holds W0..W3, o_overflow=1 after W4 completes; then o_ready=1 -> W0,W1,W2,W3 in order, and W4 never appears.
- Full with concurrent pop: FIFO full, W4 completes in the same cycle o_ready=1 pops W0 -> no overflow; drain order W1,W2,W3,W4.
- Clear: with o_overflow=1, assert i_clear one cycle -> o_overflow=0. Then i_clear coincident with a new drop -> o_overflow stays 1.
- Async reset mid-word: 2 indices accepted, 2 words in FIFO, rst pulsed between edges -> o_valid=0, o_data=0 immediately. The next 4 indices 0x01..0x04 yield 0x04030201 with o_bytes=4.
